// File: rtl/audio_pingpong_sampler.sv
`default_nettype none
// ============================================================================
// Module   : audio_pingpong_sampler
// Brief    : Ping-pong PCM capture into two sample banks with overrun tracking.
// Revision : 1.0
// ============================================================================
module audio_pingpong_sampler #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 11,
    parameter int SIGNED_OUT    = 1,
    parameter int OVR_CNT_WIDTH = 8
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic                     EN,
    input  logic                     flush,
    input  logic                     sample_valid,
    input  logic [DATA_WIDTH-1:0]    sample_data,
    input  logic [1:0]               bank_release,
    output logic [ADDR_WIDTH-1:0]    ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    output logic                     ping_we,
    output logic                     pong_we,
    output logic [1:0]               bank_full,
    output logic                     bank_done,
    output logic                     done_bank,
    output logic                     overrun,
    output logic [OVR_CNT_WIDTH-1:0] overrun_cnt
);

    logic                     wr_bank_q,   wr_bank_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q,   wr_addr_d;
    logic [1:0]               bank_full_q, bank_full_d;
    logic [ADDR_WIDTH-1:0]    ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0]    ram_wdata_q, ram_wdata_d;
    logic                     ping_we_q,   ping_we_d;
    logic                     pong_we_q,   pong_we_d;
    logic                     bank_done_q, bank_done_d;
    logic                     done_bank_q, done_bank_d;
    logic                     overrun_q,   overrun_d;
    logic [OVR_CNT_WIDTH-1:0] ovr_cnt_q,   ovr_cnt_d;

    logic [DATA_WIDTH-1:0]    w_conv;
    logic                     w_accept;
    logic                     w_drop;
    logic                     w_last;

    // Offset-binary to two's complement is just an MSB flip.
    generate
        if (SIGNED_OUT != 0) begin : g_signed
            assign w_conv = {~sample_data[DATA_WIDTH-1], sample_data[DATA_WIDTH-2:0]};
        end else begin : g_pass
            assign w_conv = sample_data;
        end
    endgenerate

    assign w_accept = EN & sample_valid & ~bank_full_q[wr_bank_q];
    assign w_drop   = EN & sample_valid &  bank_full_q[wr_bank_q];
    assign w_last   = (wr_addr_q == {ADDR_WIDTH{1'b1}});

    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        bank_full_d = bank_full_q & ~bank_release;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ping_we_d   = 1'b0;
        pong_we_d   = 1'b0;
        bank_done_d = 1'b0;
        done_bank_d = done_bank_q;
        overrun_d   = overrun_q;
        ovr_cnt_d   = ovr_cnt_q;

        if (flush) begin
            wr_bank_d   = 1'b0;
            wr_addr_d   = '0;
            bank_full_d = 2'b00;
            overrun_d   = 1'b0;
            ovr_cnt_d   = '0;
        end else if (w_accept) begin
            ram_addr_d  = wr_addr_q;
            ram_wdata_d = w_conv;
            ping_we_d   = ~wr_bank_q;
            pong_we_d   =  wr_bank_q;
            if (w_last) begin
                // A bank being written is never full, so no release can race this set.
                wr_addr_d              = '0;
                bank_full_d[wr_bank_q] = 1'b1;
                bank_done_d            = 1'b1;
                done_bank_d            = wr_bank_q;
                wr_bank_d              = ~wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
            end
        end else if (w_drop) begin
            overrun_d = 1'b1;
            if (ovr_cnt_q != {OVR_CNT_WIDTH{1'b1}}) begin
                ovr_cnt_d = ovr_cnt_q + OVR_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_bank_q   <= 1'b0;
            wr_addr_q   <= '0;
            bank_full_q <= 2'b00;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ping_we_q   <= 1'b0;
            pong_we_q   <= 1'b0;
            bank_done_q <= 1'b0;
            done_bank_q <= 1'b0;
            overrun_q   <= 1'b0;
            ovr_cnt_q   <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            bank_full_q <= bank_full_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ping_we_q   <= ping_we_d;
            pong_we_q   <= pong_we_d;
            bank_done_q <= bank_done_d;
            done_bank_q <= done_bank_d;
            overrun_q   <= overrun_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign ping_we     = ping_we_q;
    assign pong_we     = pong_we_q;
    assign bank_full   = bank_full_q;
    assign bank_done   = bank_done_q;
    assign done_bank   = done_bank_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = ovr_cnt_q;

endmodule
`default_nettype wire

// File: doc/audio_pingpong_sampler.md
Name: audio_pingpong_sampler

Overview:
- Parametrised ping-pong capture stage between the PDM deserializer and two dual-port sample RAMs (ping, pong).
- Converts offset-binary PCM samples to two's complement and writes them into alternating banks.
- Tracks bank ownership through a fill/release handshake with the consumer (DMA or CPU).
- Detects and counts overruns instead of silently overwriting unread data.

Parameters:
- DATA_WIDTH, 16, sample width in bits (input and output).
- ADDR_WIDTH, 11, bank address width; bank depth = 2^ADDR_WIDTH words.
- SIGNED_OUT, 1: 1 = invert sample MSB (subtract 2^(DATA_WIDTH-1)); 0 = pass through unchanged.
- OVR_CNT_WIDTH, 8, width of the saturating overrun counter.

Ports:
- HCLK  in  1  system clock; all logic on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- EN  in  1  capture enable.
- flush  in  1  synchronous pulse: restart capture at bank 0, address 0.
- sample_valid  in  1  single-cycle strobe from the deserializer.
- sample_data  in  DATA_WIDTH  offset-binary sample, valid with sample_valid.
- bank_release  in  2  consumer pulse; bit i returns bank i (0 = ping, 1 = pong).
- ram_addr  out  ADDR_WIDTH  write address, shared by both banks.
- ram_wdata  out  DATA_WIDTH  converted sample.
- ping_we  out  1  write strobe for bank 0.
- pong_we  out  1  write strobe for bank 1.
- bank_full  out  2  bit i = bank i filled and owned by the consumer.
- bank_done  out  1  one-cycle pulse when a bank completes.
- done_bank  out  1  index of the bank that just completed; valid with bank_done.
- overrun  out  1  sticky flag: at least one sample dropped.
- overrun_cnt  out  OVR_CNT_WIDTH  dropped-sample count, saturating.

Behaviour:
- Reset state: all outputs 0; internal wr_bank = 0, wr_addr = 0.
- Accept condition: accept = EN & sample_valid & ~bank_full[wr_bank]. All decisions use pre-edge register values.
- On accept, at the next edge:
  - ram_addr <= wr_addr.
  - ram_wdata <= conv(sample_data).
  - ping_we <= (wr_bank == 0); pong_we <= (wr_bank == 1).
  - Latency: exactly 1 cycle from sample_valid to the write strobe.
  - Strobes are 1-cycle pulses; ram_addr and ram_wdata hold their value until the next accept.
- Address wrap on accept:
  - If wr_addr != 2^ADDR_WIDTH-1: wr_addr increments.
  - Otherwise, in the same edge: wr_addr <= 0, bank_full[wr_bank] <= 1, bank_done <= 1, done_bank <= wr_bank, wr_bank toggles.
  - bank_done is asserted in the same cycle as the last write strobe.
- Drop condition: EN & sample_valid & bank_full[wr_bank].
  - No write strobe; wr_addr and wr_bank unchanged.
  - overrun <= 1; overrun_cnt increments, saturating at all-ones.
- EN low: sample_valid ignored (no write, no overrun count); pointers and flags hold.
- Release: bank_release[i] clears bank_full[i] at the next edge.
  - Releasing a bank that is not full has no effect.
  - Release and drop in the same cycle for the same bank: the sample is dropped and counted; the release still takes effect, and the next sample is accepted.
- flush (priority over everything except reset): wr_bank <= 0, wr_addr <= 0, bank_full <= 0, overrun <= 0, overrun_cnt <= 0; strobes and bank_done forced to 0 that cycle. A sample arriving with flush is discarded.
- Conversion:
  - SIGNED_OUT = 1: conv(x) = {~x[MSB], x[MSB-1:0]}; 2^(DATA_WIDTH-1) maps to 0; no saturation is needed.
  - SIGNED_OUT = 0: conv(x) = x.
- Both banks full: every further sample is dropped until a release.
- Reset mid-fill: all state returns to the reset values immediately (asynchronous); partial bank contents are abandoned.
- Overrun counter: held at all-ones once saturated; cleared only by reset or flush.

Test Plan:
- ADDR_WIDTH=3, EN=1, 8 samples 0x8000..0x8007 → ping_we at addr 0..7, wdata 0x0000..0x0007; on 8th write bank_done=1, done_bank=0, bank_full=01; next sample → pong_we, addr 0.
- Conversion, SIGNED_OUT=1: inputs 0x0000, 0xFFFF, 0x8000 → wdata 0x8000, 0x7FFF, 0x0000. SIGNED_OUT=0: 0x1234 → 0x1234.
- Fill ping and pong with no release (16 samples), then 3 more → no strobes; overrun=1, overrun_cnt=3. Pulse bank_release=01 → next sample written to ping addr 0.
- Release ping in the same cycle as a sample while wr_bank=0 is full → sample dropped, overrun_cnt +1, bank_full[0] cleared; following sample accepted at ping addr 0.
- OVR_CNT_WIDTH=2, both banks full, 6 drops → overrun_cnt=3 (saturated); then flush → all flags and count 0, next write at ping addr 0.
- EN=0 with 5 sample_valid pulses → no strobes, overrun_cnt unchanged. Assert HRESETn=0 mid-bank (addr 5) → outputs 0 asynchronously; after release first write at ping addr 0.
